sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 4, number of adder results (beats) per accumulation frame, legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clr  input  1  synchronous frame clear.
REQ-005 SHALL have port sum  input  4  sum output of upstream 4-bit full adder.
REQ-006 SHALL have port c_out  input  1  carry output of upstream 4-bit full adder.
REQ-007 SHALL have port in_valid  input  1  sum/c_out valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port acc  output  8  running/final accumulated total.
REQ-010 SHALL have port cnt  output  4  beats accepted in current frame.
REQ-011 SHALL have port out_valid  output  1  acc holds completed frame result.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port ovf  output  1  sticky frame overflow flag.

Function
REQ-014 SHALL define a beat as in_valid && in_ready; beat value = unsigned 5-bit {c_out, sum}, range 0..31.
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE; in_ready = 1 in IDLE/ACCUM, 0 in DONE; out_valid = 1 only in DONE.
REQ-016 SHALL, on a beat in IDLE: acc <= value, cnt <= 1, ovf <= 0; go ACCUM, or DONE if N_SAMPLES == 1.
REQ-017 SHALL, on a beat in ACCUM: acc <= acc + value (9-bit internal sum), cnt <= cnt + 1; go DONE when new cnt == N_SAMPLES.
REQ-018 SHALL hold acc, cnt, ovf and state on any cycle without a beat (in_valid low: no change).
REQ-019 SHALL assert out_valid the cycle after the N_SAMPLES-th beat (latency 1 cycle).
REQ-020 SHALL, in DONE, hold acc/cnt/ovf stable and ignore in_valid until out_ready = 1; then return to IDLE, out_valid low next cycle.
REQ-021 SHALL set ovf when bit 8 of the internal 9-bit sum is 1; ovf stays set until next frame start, clr, or reset.
REQ-022 SHALL treat clr as highest synchronous priority in every state: next cycle state IDLE, acc 0, cnt 0, ovf 0; concurrent beat discarded.
REQ-023 SHALL keep acc visible every cycle (running total); only out_valid qualifies it as final.

Reset
REQ-024 SHALL, while rst_n = 0, force immediately (no clock): state IDLE, acc 0, cnt 0, ovf 0, out_valid 0, in_ready 1.
REQ-025 SHALL abandon any partial frame or pending DONE result on reset; first beat after release starts a new frame.

Configuration
REQ-026 SHALL support macro SUM_ACC_SATURATE_EN: defined -> on overflow acc clamps to 255 (and stays 255 for remaining beats of the frame); undefined -> acc wraps modulo 256.
REQ-027 SHALL set ovf identically with and without SUM_ACC_SATURATE_EN.

Verification
REQ-028 SHALL cover: N_SAMPLES=4, beats {c_out,sum}={0,7},{0,7},{0,7},{1,15} back-to-back -> acc=52, cnt=4, ovf=0, out_valid high 1 cycle after 4th beat.
REQ-029 SHALL cover: same beats with in_valid high every other cycle -> identical acc=52, cnt increments only on beats.
REQ-030 SHALL cover: DONE with out_ready low 5 cycles and in_valid high -> out_valid=1, in_ready=0, acc=52 held; out_ready pulse -> IDLE next cycle.
REQ-031 SHALL cover: N_SAMPLES=9, nine beats {1,15} -> total 279; without macro acc=23, ovf=1; with SUM_ACC_SATURATE_EN acc=255, ovf=1.
REQ-032 SHALL cover: clr after 2 beats of value 10 (acc=20) -> acc=0, cnt=0, IDLE; following 4 beats of 5 -> acc=20, out_valid.
REQ-033 SHALL cover: rst_n low mid-ACCUM (between clock edges) -> acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/sum_accumulator.sv
// Frames N_SAMPLES beats of {c_out, sum} from an upstream 4-bit adder into an 8-bit total.
// Optional macro SUM_ACC_SATURATE_EN clamps the total at 255 on overflow instead of wrapping.
module sum_accumulator #(
    parameter int N_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [3:0] sum,
    input  logic       c_out,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] acc,
    output logic [3:0] cnt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ovf
);

    localparam logic [3:0] LAST_CNT = 4'(N_SAMPLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;

    logic       beat;
    logic [4:0] beatValue;
    logic [8:0] sumWide;
    logic [3:0] cntNext;
    logic       frameEnd;

    assign beat      = in_valid && in_ready;
    assign beatValue = {c_out, sum};
    assign sumWide   = {1'b0, acc_q} + {4'b0000, beatValue};
    assign cntNext   = (state_q == IDLE) ? 4'd1 : cnt_q + 4'd1;
    assign frameEnd  = (cntNext == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // clr outranks everything, including a pending result in DONE.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat) begin
                        state_d = frameEnd ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != DONE);
        out_valid = (state_q == DONE);
    end

    // A beat in IDLE opens a new frame; later beats add into the 9-bit sum whose carry feeds ovf.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = 8'd0;
            cnt_d = 4'd0;
            ovf_d = 1'b0;
        end else if (beat) begin
            cnt_d = cntNext;
            if (state_q == IDLE) begin
                acc_d = {3'b000, beatValue};
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q | sumWide[8];
`ifdef SUM_ACC_SATURATE_EN
                acc_d = (ovf_q || sumWide[8]) ? 8'hFF : sumWide[7:0];
`else
                acc_d = sumWide[7:0];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 8'd0;
            cnt_q <= 4'd0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: instance A (4 beats/frame) under random traffic,
// instance B (9 beats/frame) for the overflow boundary.
module tb_sum_accumulator;

    localparam int NA = 4;
    localparam int NB = 9;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       clrA, cOutA, inValidA, inReadyA, outValidA, outReadyA, ovfA;
    logic [3:0] sumA, cntA;
    logic [7:0] accA;

    logic       clrB, cOutB, inValidB, inReadyB, outValidB, outReadyB, ovfB;
    logic [3:0] sumB, cntB;
    logic [7:0] accB;

    int errors     = 0;
    int checks     = 0;
    int cycleCount = 0;

    typedef struct {
        int acc;
        int cnt;
        int ovf;
        int cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    logic prevValid = 1'b0;

    int modelCnt   = 0;
    int modelTotal = 0;

    sum_accumulator #(.N_SAMPLES(NA)) dutA (
        .clk(clk), .rst_n(rst_n), .clr(clrA), .sum(sumA), .c_out(cOutA),
        .in_valid(inValidA), .in_ready(inReadyA), .acc(accA), .cnt(cntA),
        .out_valid(outValidA), .out_ready(outReadyA), .ovf(ovfA)
    );

    sum_accumulator #(.N_SAMPLES(NB)) dutB (
        .clk(clk), .rst_n(rst_n), .clr(clrB), .sum(sumB), .c_out(cOutB),
        .in_valid(inValidB), .in_ready(inReadyB), .acc(accB), .cnt(cntB),
        .out_valid(outValidB), .out_ready(outReadyB), .ovf(ovfB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Reference: a frame's total is a plain sum of beat values; overflow means it passed 255.
    function automatic int modelAcc(input int total);
`ifdef SUM_ACC_SATURATE_EN
        return (total > 255) ? 255 : total;
`else
        return total % 256;
`endif
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    // Monitor: pops one expectation when a result appears, then checks it is held while presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (outValidA && !prevValid) begin
                if (expQ.size() == 0) begin
                    check("unexpectedResult", 1, 0);
                end else begin
                    cur = expQ.pop_front();
                    check("resultAcc", int'(accA), cur.acc);
                    check("resultCnt", int'(cntA), cur.cnt);
                    check("resultOvf", int'(ovfA), cur.ovf);
                    check("resultLatency", cycleCount, cur.cyc);
                    check("doneInReady", int'(inReadyA), 0);
                end
            end else if (outValidA && prevValid) begin
                check("heldAcc", int'(accA), cur.acc);
                check("heldCnt", int'(cntA), cur.cnt);
                check("heldOvf", int'(ovfA), cur.ovf);
                check("heldInReady", int'(inReadyA), 0);
            end
        end
        prevValid = outValidA;
    end

    task automatic applyStimulus(input int value, input int gap);
        logic [4:0] v5;
        exp_t e;
        v5 = value[4:0];
        repeat (gap) begin
            inValidA = 1'b0;
            sumA     = 4'($urandom);
            @(posedge clk); #1;
        end
        inValidA = 1'b1;
        {cOutA, sumA} = v5;
        @(posedge clk); #1;
        inValidA = 1'b0;
        modelCnt++;
        modelTotal += value;
        check("runCnt", int'(cntA), modelCnt);
        check("runAcc", int'(accA), modelAcc(modelTotal));
        check("runOvf", int'(ovfA), (modelTotal > 255) ? 1 : 0);
        if (modelCnt == NA) begin
            e.acc = modelAcc(modelTotal);
            e.cnt = modelCnt;
            e.ovf = (modelTotal > 255) ? 1 : 0;
            e.cyc = cycleCount;
            expQ.push_back(e);
        end
    endtask

    task automatic checkOutput(input int hold, input logic validDuringHold);
        int lastAcc;
        lastAcc = modelAcc(modelTotal);
        repeat (hold) begin
            inValidA = validDuringHold;
            sumA     = 4'($urandom);
            @(posedge clk); #1;
        end
        outReadyA = 1'b1;
        inValidA  = validDuringHold;
        @(posedge clk); #1;
        outReadyA = 1'b0;
        inValidA  = 1'b0;
        check("releaseOutValid", int'(outValidA), 0);
        check("releaseInReady", int'(inReadyA), 1);
        check("idleAccHeld", int'(accA), lastAcc);
        modelCnt   = 0;
        modelTotal = 0;
    endtask

    task automatic clearA(input logic withBeat);
        clrA     = 1'b1;
        inValidA = withBeat;
        {cOutA, sumA} = 5'd9;
        @(posedge clk); #1;
        clrA     = 1'b0;
        inValidA = 1'b0;
        check("clrAcc", int'(accA), 0);
        check("clrCnt", int'(cntA), 0);
        check("clrOvf", int'(ovfA), 0);
        check("clrOutValid", int'(outValidA), 0);
        check("clrInReady", int'(inReadyA), 1);
        modelCnt   = 0;
        modelTotal = 0;
    endtask

    task automatic asyncReset(input int delay);
        #delay;
        rst_n = 1'b0;
        #1;
        check("rstAcc", int'(accA), 0);
        check("rstCnt", int'(cntA), 0);
        check("rstOvf", int'(ovfA), 0);
        check("rstOutValid", int'(outValidA), 0);
        check("rstInReady", int'(inReadyA), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        modelCnt   = 0;
        modelTotal = 0;
    endtask

    task automatic sendBeatB(input int value);
        logic [4:0] v5;
        v5 = value[4:0];
        inValidB = 1'b1;
        {cOutB, sumB} = v5;
        @(posedge clk); #1;
        inValidB = 1'b0;
    endtask

    task automatic runFrameB(input int lo, input int hi);
        int total;
        int v;
        total = 0;
        for (int i = 0; i < NB; i++) begin
            v = $urandom_range(hi, lo);
            sendBeatB(v);
            total += v;
            if (i < NB - 1) begin
                check("bRunOutValid", int'(outValidB), 0);
                check("bRunOvf", int'(ovfB), (total > 255) ? 1 : 0);
            end
        end
        check("bOutValid", int'(outValidB), 1);
        check("bInReady", int'(inReadyB), 0);
        check("bAcc", int'(accB), modelAcc(total));
        check("bCnt", int'(cntB), NB);
        check("bOvf", int'(ovfB), (total > 255) ? 1 : 0);
        outReadyB = 1'b1;
        @(posedge clk); #1;
        outReadyB = 1'b0;
        check("bRelease", int'(outValidB), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clrA = 0; cOutA = 0; sumA = 0; inValidA = 0; outReadyA = 0;
        clrB = 0; cOutB = 0; sumB = 0; inValidB = 0; outReadyB = 0;
        #1 rst_n = 1'b0;
        #11;
        check("initAcc", int'(accA), 0);
        check("initCnt", int'(cntA), 0);
        check("initOvf", int'(ovfA), 0);
        check("initOutValid", int'(outValidA), 0);
        check("initInReady", int'(inReadyA), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] back-to-back frame 7,7,7,31 with stalled consumer");
        applyStimulus(7, 0);
        applyStimulus(7, 0);
        applyStimulus(7, 0);
        applyStimulus(31, 0);
        check("frame52Acc", int'(accA), 52);
        checkOutput(5, 1'b1);

        $display("[TB] same frame with gaps between beats");
        applyStimulus(7, 1);
        applyStimulus(7, 1);
        applyStimulus(7, 1);
        applyStimulus(31, 1);
        check("gapFrameAcc", int'(accA), 52);
        checkOutput(0, 1'b0);

        $display("[TB] clear mid-frame then refill");
        applyStimulus(10, 0);
        applyStimulus(10, 0);
        clearA(1'b1);
        for (int i = 0; i < NA; i++) applyStimulus(5, 0);
        check("refillAcc", int'(accA), 20);
        checkOutput(2, 1'b0);

        $display("[TB] clear while result pending");
        for (int i = 0; i < NA; i++) applyStimulus($urandom_range(31, 0), 0);
        clearA(1'b1);

        $display("[TB] asynchronous reset mid-frame and while done");
        applyStimulus(12, 0);
        applyStimulus(3, 0);
        asyncReset(2);
        for (int i = 0; i < NA; i++) applyStimulus($urandom_range(31, 0), 0);
        asyncReset(6);

        $display("[TB] random frames");
        for (int f = 0; f < 25; f++) begin
            for (int b = 0; b < NA; b++) begin
                applyStimulus($urandom_range(31, 0), $urandom_range(2, 0));
            end
            checkOutput($urandom_range(4, 0), 1'($urandom_range(1, 0)));
        end

        $display("[TB] nine-beat frames crossing 255");
        for (int i = 0; i < NB; i++) begin
            sendBeatB(31);
            if (i == 7) begin
                check("b248Acc", int'(accB), 248);
                check("b248Ovf", int'(ovfB), 0);
            end
        end
        check("b279OutValid", int'(outValidB), 1);
        check("b279Acc", int'(accB), modelAcc(279));
        check("b279Ovf", int'(ovfB), 1);
        check("b279Cnt", int'(cntB), NB);
        outReadyB = 1'b1;
        @(posedge clk); #1;
        outReadyB = 1'b0;
        check("b279Release", int'(outValidB), 0);
        for (int i = 0; i < 4; i++) runFrameB(20, 31);

        @(posedge clk); #1;
        check("scoreboardDrain", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
